// File: rtl/fibonacci_pkg.sv
// Shared definitions for the Fibonacci term streamer: state encoding and default widths.
package fibonacci_pkg;
  localparam int WIDTH_DEF       = 16;
  localparam int COUNT_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/fibonacci_step.sv
// Next-term adder: WIDTH-bit sum of the two most recent terms plus the carry out of WIDTH bits.
module fibonacci_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_A,
  input  logic [WIDTH-1:0] i_B,
  output logic [WIDTH-1:0] o_Sum,
  output logic             o_Carry
);
  assign {o_Carry, o_Sum} = {1'b0, i_A} + {1'b0, i_B};
endmodule

// File: rtl/fibonacci_stream.sv
// Streams Fibonacci terms from two seeds over a valid/ready port, one term per accept.
// Handshake: a term transfers on a rising edge where o_Valid=1 and i_Ready=1; while
// o_Valid=1 and i_Ready=0 the term and its flags hold unchanged.
module fibonacci_stream
  import fibonacci_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int COUNT_WIDTH = COUNT_WIDTH_DEF
) (
  input  logic                   i_Clock,
  input  logic                   i_Reset,
  input  logic                   i_Start,
  input  logic                   i_Abort,
  input  logic [WIDTH-1:0]       i_Seed0,
  input  logic [WIDTH-1:0]       i_Seed1,
  input  logic [COUNT_WIDTH-1:0] i_Length,
  input  logic                   i_Wrap,
  input  logic                   i_Ready,
  output logic                   o_Valid,
  output logic [WIDTH-1:0]       o_Value,
  output logic [COUNT_WIDTH-1:0] o_Index,
  output logic                   o_Last,
  output logic                   o_Overflow,
  output logic                   o_Busy,
  output logic                   o_Done,
  output logic [1:0]             o_State
);
  state_t                 r_state;
  logic                   r_valid;
  logic [WIDTH-1:0]       r_value;
  logic [WIDTH-1:0]       r_next;
  logic [COUNT_WIDTH-1:0] r_index;
  logic [COUNT_WIDTH-1:0] r_length;
  logic                   r_wrap;
  logic                   r_last;
  logic                   r_overflow;
  logic                   r_done;

  logic [WIDTH-1:0]       w_sum;
  logic                   w_carry;
  logic                   w_accept;
  logic [COUNT_WIDTH-1:0] w_index_inc;
  logic [COUNT_WIDTH-1:0] w_last_idx;

  // w_sum is the term after r_next; its carry decides whether r_next is the final term.
  fibonacci_step #(.WIDTH(WIDTH)) u_step (
    .i_A     (r_value),
    .i_B     (r_next),
    .o_Sum   (w_sum),
    .o_Carry (w_carry)
  );

  assign w_accept    = r_valid & i_Ready;
  assign w_index_inc = r_index + COUNT_WIDTH'(1);
  assign w_last_idx  = r_length - COUNT_WIDTH'(1);

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_state    <= ST_IDLE;
      r_valid    <= 1'b0;
      r_value    <= '0;
      r_next     <= '0;
      r_index    <= '0;
      r_length   <= '0;
      r_wrap     <= 1'b0;
      r_last     <= 1'b0;
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (i_Start && (i_Length != '0)) begin
            r_state    <= ST_RUN;
            r_valid    <= 1'b1;
            r_value    <= i_Seed0;
            r_next     <= i_Seed1;
            r_index    <= '0;
            r_length   <= i_Length;
            r_wrap     <= i_Wrap;
            r_last     <= (i_Length == COUNT_WIDTH'(1));
            r_overflow <= 1'b0;
          end
        end
        ST_RUN: begin
          if (i_Abort || (w_accept && r_last && !r_wrap)) begin
            r_state    <= i_Abort ? ST_IDLE : ST_DONE;
            r_done     <= !i_Abort;
            r_valid    <= 1'b0;
            r_value    <= '0;
            r_next     <= '0;
            r_index    <= '0;
            r_last     <= 1'b0;
            r_overflow <= 1'b0;
          end else if (w_accept && r_last) begin
            r_value    <= i_Seed0;
            r_next     <= i_Seed1;
            r_index    <= '0;
            r_last     <= (r_length == COUNT_WIDTH'(1));
            r_overflow <= 1'b0;
          end else if (w_accept) begin
            r_value    <= r_next;
            r_next     <= w_sum;
            r_index    <= w_index_inc;
            r_last     <= (w_index_inc == w_last_idx) || w_carry;
            r_overflow <= w_carry;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_Valid    = r_valid;
  assign o_Value    = r_value;
  assign o_Index    = r_index;
  assign o_Last     = r_last;
  assign o_Overflow = r_overflow;
  assign o_Busy     = (r_state != ST_IDLE);
  assign o_Done     = r_done;
  assign o_State    = r_state;
endmodule

// File: tb/tb_fibonacci_stream.sv
// Directed bench for fibonacci_stream: per-cycle vector table plus hand-written sequences.
module tb_fibonacci_stream;
  import fibonacci_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, abort, ready, wrap;
  logic [15:0] seed0, seed1;
  logic [7:0]  len;
  logic        valid, last, ovf, busy, done;
  logic [15:0] value;
  logic [7:0]  index;
  logic [1:0]  state;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        start, abort, ready;
    logic [15:0] s0, s1;
    logic [7:0]  len;
    logic        wrap;
    logic        valid;
    logic [15:0] value;
    logic [7:0]  index;
    logic        last, ovf, busy, done;
  } vec_t;

  vec_t tbl[13];

  fibonacci_stream #(.WIDTH(16), .COUNT_WIDTH(8)) dut (
    .i_Clock(clk), .i_Reset(rst), .i_Start(start), .i_Abort(abort),
    .i_Seed0(seed0), .i_Seed1(seed1), .i_Length(len), .i_Wrap(wrap),
    .i_Ready(ready), .o_Valid(valid), .o_Value(value), .o_Index(index),
    .o_Last(last), .o_Overflow(ovf), .o_Busy(busy), .o_Done(done), .o_State(state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic e_valid, input logic [15:0] e_value,
                         input logic [7:0] e_index, input logic e_last, input logic e_ovf,
                         input logic e_busy, input logic e_done);
    chk({tag, ".valid"}, 32'(valid), 32'(e_valid));
    if (e_valid) begin
      chk({tag, ".value"}, 32'(value), 32'(e_value));
      chk({tag, ".index"}, 32'(index), 32'(e_index));
      chk({tag, ".last"},  32'(last),  32'(e_last));
      chk({tag, ".ovf"},   32'(ovf),   32'(e_ovf));
    end
    chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
    chk({tag, ".done"}, 32'(done), 32'(e_done));
  endtask

  function automatic vec_t mk(input logic st, ab, rd, input logic [15:0] s0, s1,
                              input logic [7:0] ln, input logic wr, input logic v,
                              input logic [15:0] val, input logic [7:0] idx,
                              input logic l, o, b, d);
    vec_t r;
    r.start = st; r.abort = ab; r.ready = rd; r.s0 = s0; r.s1 = s1; r.len = ln;
    r.wrap = wr; r.valid = v; r.value = val; r.index = idx; r.last = l; r.ovf = o;
    r.busy = b; r.done = d;
    return r;
  endfunction

  task automatic idle_inputs();
    start = 1'b0; abort = 1'b0; ready = 1'b1;
  endtask

  // Runs a full non-wrapping sequence with seeds 0/1, checking every term against a running model.
  task automatic run_seq(input string tag, input logic [7:0] ln, input int last_k,
                         input logic exp_ovf, input int stall_k);
    logic [31:0] a, b, t;
    seed0 = 16'd0; seed1 = 16'd1; len = ln; wrap = 1'b0; start = 1'b1; ready = 1'b1;
    step();
    start = 1'b0;
    a = 0; b = 1;
    for (int k = 0; k <= last_k; k++) begin
      chk_out($sformatf("%s.k%0d", tag, k), 1'b1, a[15:0], 8'(k), (k == last_k),
              exp_ovf && (k == last_k), 1'b1, 1'b0);
      if (k == stall_k) begin
        ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          step();
          chk_out($sformatf("%s.stall%0d", tag, s), 1'b1, a[15:0], 8'(k), 1'b0, 1'b0, 1'b1, 1'b0);
        end
        ready = 1'b1;
      end
      step();
      t = a + b; a = b; b = t;
    end
    chk_out({tag, ".done"}, 1'b0, 16'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    chk_out({tag, ".idle"}, 1'b0, 16'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; seed0 = '0; seed1 = '0; len = '0; wrap = 1'b0;
    idle_inputs();
    #2;
    chk_out("reset", 1'b0, 16'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset.state", 32'(state), 32'(ST_IDLE));
    chk("reset.value", 32'(value), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_seq("fib24", 8'd24, 23, 1'b0, 5);

    run_seq("fib255", 8'd255, 24, 1'b1, -1);

    tbl[0]  = mk(1,0,1, 16'd2,16'd3,8'd3,1, 1,16'd2,8'd0,0,0,1,0);
    tbl[1]  = mk(0,0,1, 16'd2,16'd3,8'd3,1, 1,16'd3,8'd1,0,0,1,0);
    tbl[2]  = mk(0,0,1, 16'd2,16'd3,8'd3,1, 1,16'd5,8'd2,1,0,1,0);
    tbl[3]  = mk(0,0,1, 16'd2,16'd3,8'd3,1, 1,16'd2,8'd0,0,0,1,0);
    tbl[4]  = mk(0,0,1, 16'd2,16'd3,8'd3,1, 1,16'd3,8'd1,0,0,1,0);
    tbl[5]  = mk(0,0,1, 16'd2,16'd3,8'd3,1, 1,16'd5,8'd2,1,0,1,0);
    tbl[6]  = mk(1,0,1, 16'd2,16'd3,8'd0,1, 1,16'd2,8'd0,0,0,1,0);
    tbl[7]  = mk(0,1,1, 16'd2,16'd3,8'd3,1, 0,16'd0,8'd0,0,0,0,0);
    tbl[8]  = mk(1,0,1, 16'd2,16'd3,8'd0,0, 0,16'd0,8'd0,0,0,0,0);
    tbl[9]  = mk(1,0,1, 16'd7,16'd9,8'd1,0, 1,16'd7,8'd0,1,0,1,0);
    tbl[10] = mk(0,0,0, 16'd7,16'd9,8'd1,0, 1,16'd7,8'd0,1,0,1,0);
    tbl[11] = mk(0,0,1, 16'd7,16'd9,8'd1,0, 0,16'd0,8'd0,0,0,1,1);
    tbl[12] = mk(0,0,1, 16'd7,16'd9,8'd1,0, 0,16'd0,8'd0,0,0,0,0);
    for (int i = 0; i < 13; i++) begin
      start = tbl[i].start; abort = tbl[i].abort; ready = tbl[i].ready;
      seed0 = tbl[i].s0; seed1 = tbl[i].s1; len = tbl[i].len; wrap = tbl[i].wrap;
      step();
      chk_out($sformatf("tbl%0d", i), tbl[i].valid, tbl[i].value, tbl[i].index,
              tbl[i].last, tbl[i].ovf, tbl[i].busy, tbl[i].done);
    end
    idle_inputs();

    // Abort coinciding with an accept of index 4 (value 3).
    seed0 = 16'd0; seed1 = 16'd1; len = 8'd24; wrap = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 4; k++) step();
    chk_out("abort.pre", 1'b1, 16'd3, 8'd4, 1'b0, 1'b0, 1'b1, 1'b0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_out("abort.post", 1'b0, 16'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk_out("abort.after", 1'b0, 16'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a run at index 10 (value 55).
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 10; k++) step();
    chk_out("rstmid.pre", 1'b1, 16'd55, 8'd10, 1'b0, 1'b0, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk_out("rstmid.async", 1'b0, 16'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rstmid.value", 32'(value), 32'd0);
    chk("rstmid.index", 32'(index), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    len = 8'd0; start = 1'b1;
    step();
    chk_out("rstmid.len0", 1'b0, 16'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    seed0 = 16'd4; seed1 = 16'd6; len = 8'd5;
    step();
    start = 1'b0;
    chk_out("rstmid.start", 1'b1, 16'd4, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    chk_out("rstmid.t1", 1'b1, 16'd6, 8'd1, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    chk_out("rstmid.t2", 1'b1, 16'd10, 8'd2, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
